// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with WB/link bypass and busy scoreboard
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int LINK_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     link_en,
    input  logic [DATA_W-1:0]        link_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     any_busy
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
    localparam logic LINK_ON = LINK_REG != 0;
    localparam logic BYP_ON = BYPASS != 0;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy, busy_nxt;
    logic              link_wr;

    assign link_wr  = link_en && LINK_ON;
    assign any_busy = |busy;

    // next busy vector: writes release a register, a new issue reserves it and takes precedence
    always_comb begin
        busy_nxt = busy;
        if (wr_en) busy_nxt[wr_addr] = 1'b0;
        if (link_wr) busy_nxt[LINK_A] = 1'b0;
        if (iss_en && iss_addr != '0) busy_nxt[iss_addr] = 1'b1;
    end

    // array and scoreboard update; link is applied last so it wins over WB to the same index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
            busy <= '0;
        end else begin
            if (wr_en && wr_addr != '0) regs[wr_addr] <= wr_data;
            if (link_wr) regs[LINK_A] <= link_data;
            busy <= busy_nxt;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              lk, wb;
        assign a  = rd_addr[i*ADDR_W +: ADDR_W];
        assign lk = BYP_ON && link_wr && a == LINK_A;
        assign wb = BYP_ON && wr_en && a == wr_addr;
        assign rd_data[i*DATA_W +: DATA_W] = a == '0 ? '0 : lk ? link_data : wb ? wr_data : regs[a];
        assign rd_busy[i] = a != '0 && busy[a] && !lk && !wb;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of reads, bypass, register 0, link priority, scoreboard and async reset
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en, link_en, iss_en;
    logic [4:0]  wr_addr, iss_addr;
    logic [31:0] wr_data, link_data;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        any_busy;
    int          checks = 0;
    int          errors = 0;

    regfile_mp dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .link_en(link_en), .link_data(link_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .any_busy(any_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet();
        wr_en = 0; link_en = 0; iss_en = 0;
        wr_addr = 0; iss_addr = 0; wr_data = 0; link_data = 0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    initial begin
        quiet();
        rd_addr = 0;
        rst_n = 0;
        repeat (2) cyc();
        rst_n = 1;
        cyc();
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            chk($sformatf("rst_d0[%0d]", i), rd_data[31:0], 0);
            chk($sformatf("rst_d1[%0d]", i), rd_data[63:32], 0);
            chk($sformatf("rst_busy[%0d]", i), {30'b0, rd_busy}, 0);
        end
        chk("rst_any", {31'b0, any_busy}, 0);

        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        rd(5, 6);
        chk("wb_bypass", rd_data[31:0], 32'hDEADBEEF);
        chk("wb_other", rd_data[63:32], 0);
        cyc(); quiet();
        rd(5, 5);
        chk("wb_array0", rd_data[31:0], 32'hDEADBEEF);
        chk("wb_array1", rd_data[63:32], 32'hDEADBEEF);

        wr_en = 1; wr_addr = 0; wr_data = 32'h1234;
        rd(0, 0);
        chk("r0_same", rd_data[31:0], 0);
        cyc(); quiet();
        rd(0, 5);
        chk("r0_next", rd_data[31:0], 0);
        chk("r0_keep5", rd_data[63:32], 32'hDEADBEEF);

        link_en = 1; link_data = 32'h00400008;
        wr_en = 1; wr_addr = 31; wr_data = 32'h55;
        rd(31, 31);
        chk("link_byp0", rd_data[31:0], 32'h00400008);
        chk("link_byp1", rd_data[63:32], 32'h00400008);
        cyc(); quiet();
        rd(31, 0);
        chk("link_array", rd_data[31:0], 32'h00400008);

        iss_en = 1; iss_addr = 8;
        rd(8, 0);
        chk("iss_same", {30'b0, rd_busy}, 0);
        chk("iss_same_any", {31'b0, any_busy}, 0);
        cyc(); quiet();
        rd(8, 8);
        chk("iss_next", {30'b0, rd_busy}, 2'b11);
        chk("iss_any", {31'b0, any_busy}, 1);
        wr_en = 1; wr_addr = 8; wr_data = 32'h77;
        rd(8, 0);
        chk("clr_busy", {30'b0, rd_busy}, 0);
        chk("clr_data", rd_data[31:0], 32'h77);
        cyc(); quiet();
        rd(8, 0);
        chk("clr_after", {30'b0, rd_busy}, 0);
        chk("clr_any", {31'b0, any_busy}, 0);
        chk("clr_array", rd_data[31:0], 32'h77);

        iss_en = 1; iss_addr = 8;
        cyc(); quiet();
        iss_en = 1; iss_addr = 8; wr_en = 1; wr_addr = 8; wr_data = 32'h88;
        cyc(); quiet();
        rd(8, 0);
        chk("set_wins", {30'b0, rd_busy}, 2'b01);
        chk("set_wins_data", rd_data[31:0], 32'h88);
        wr_en = 1; wr_addr = 8; wr_data = 32'h88;
        cyc(); quiet();
        iss_en = 1; iss_addr = 0;
        cyc(); quiet();
        rd(0, 8);
        chk("iss0_any", {31'b0, any_busy}, 0);
        chk("iss0_busy", {30'b0, rd_busy}, 0);

        wr_en = 1; wr_addr = 3; wr_data = 32'h33;
        cyc();
        wr_addr = 9; wr_data = 32'h99;
        cyc(); quiet();
        iss_en = 1; iss_addr = 3;
        cyc();
        iss_addr = 9;
        cyc(); quiet();
        rd(3, 9);
        chk("pre_busy", {30'b0, rd_busy}, 2'b11);
        chk("pre_d0", rd_data[31:0], 32'h33);
        chk("pre_d1", rd_data[63:32], 32'h99);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_any", {31'b0, any_busy}, 0);
        chk("arst_busy", {30'b0, rd_busy}, 0);
        chk("arst_d0", rd_data[31:0], 0);
        chk("arst_d1", rd_data[63:32], 0);
        @(negedge clk);
        rst_n = 1;
        cyc();
        rd(3, 9);
        chk("post_busy", {30'b0, rd_busy}, 0);
        chk("post_d0", rd_data[31:0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the pipelined MIPS core, sitting in ID.
- Generalises the single WB-write / two-read file with configurable width, depth and read-port count.
- Bypasses same-cycle WB and link writes to every read port.
- Adds a per-register busy scoreboard so ID can detect RAW hazards on in-flight destinations.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports, 1..4.
- LINK_REG, 31, index written by the link port.
- BYPASS, 1, 1 = WB/link data forwarded combinationally to read ports; 0 = array data only.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  WB write request (regwre AND wrctr already combined upstream).
- wr_addr  input  ADDR_W  WB destination index.
- wr_data  input  DATA_W  WB data.
- link_en  input  1  link write request.
- link_data  input  DATA_W  return address written to LINK_REG.
- iss_en  input  1  instruction issued with a register destination; reserve iss_addr.
- iss_addr  input  ADDR_W  destination being reserved.
- rd_addr  input  NUM_RD*ADDR_W  read indices; port i at [i*ADDR_W +: ADDR_W].
- rd_data  output  NUM_RD*DATA_W  read data; port i at [i*DATA_W +: DATA_W].
- rd_busy  output  NUM_RD  port i source has a pending producer.
- any_busy  output  1  OR of all busy bits, used for drain/flush checks.

Behaviour:
- Reset: while rst_n=0, all registers clear to 0 and all busy bits clear to 0. Effect is immediate (asynchronous), independent of clk.
  - After reset, rd_data = 0 and rd_busy = 0 for every port; any_busy = 0.
  - Reset asserted mid-operation discards all pending reservations.
- Register 0:
  - Always reads 0.
  - Writes to index 0 are ignored, on both WB and link (LINK_REG=0 disables the link path).
  - iss_addr=0 never sets a busy bit.
- Write, effective on the rising edge:
  - wr_en=1, wr_addr!=0: reg[wr_addr] <= wr_data.
  - link_en=1: reg[LINK_REG] <= link_data.
  - Both enabled with wr_addr==LINK_REG: link wins.
  - Written value is visible from the array on the cycle after the edge.
- Read: combinational, 0-cycle latency, per port, in priority order:
  1. addr==0 -> 0.
  2. BYPASS=1 and link_en and addr==LINK_REG -> link_data.
  3. BYPASS=1 and wr_en and addr==wr_addr -> wr_data.
  4. Otherwise reg[addr].
- Scoreboard, one bit per register:
  - Set on the edge when iss_en=1 and iss_addr!=0.
  - Cleared on the edge by a WB write (wr_en, wr_addr) or a link write (link_en) to that index.
  - Set and clear on the same index in the same cycle: set wins, since the new producer supersedes.
  - Multiple outstanding producers to one index are not tracked. The upstream hazard unit must stall issue on rd_busy so that at most one producer is outstanding per register.
- rd_busy[i]:
  - Equals busy[addr_i], except it is forced to 0 when addr_i==0.
  - Also forced to 0 when the same cycle carries a clearing write to addr_i and BYPASS=1, because the data is forwarded.
  - With BYPASS=0, a clearing write does not mask rd_busy in that cycle.
- iss_en has no effect on rd_busy in the same cycle; the reservation becomes visible next cycle.
- All read ports are independent. Identical addresses on several ports return identical data.

Test Plan:
- Reset then read all 32 indices on both ports -> rd_data=0 and rd_busy=0 every index; any_busy=0.
- Write wr_addr=5, wr_data=0xDEADBEEF; same cycle rd_addr0=5 -> port0 shows 0xDEADBEEF via bypass. Next cycle with wr_en=0 -> still 0xDEADBEEF from the array.
- wr_en with wr_addr=0, data 0x1234 -> reads of index 0 return 0 in both the same and the next cycle.
- link_en with link_data=0x00400008 and wr_en with wr_addr=31, wr_data=0x55 in the same cycle -> port reading 31 shows 0x00400008; the array holds 0x00400008 afterwards.
- Scoreboard sequence:
  - Issue iss_addr=8 -> next cycle rd_busy=1 for a port reading 8.
  - WB to 8 with data 0x77 -> rd_busy=0 in that cycle and data 0x77.
  - Simultaneous iss_addr=8 and WB to 8 -> busy remains 1 the following cycle.
- Reserve indices 3 and 9, then pulse rst_n=0 between clock edges -> any_busy drops to 0 immediately, and reg[3] and reg[9] read 0.
